// File: rtl/nn_host_bridge.sv
`default_nettype none
// ============================================================================
// Module      : nn_host_bridge
// Description : CPU/neural-engine bridge: shared-RAM arbitration, run control
//               FSM, result capture, run-cycle counter and level interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module nn_host_bridge #(
    parameter int RAM_AW = 10,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_re,
    input  logic              cpu_we,
    input  logic [11:0]       cpu_addr,
    input  logic [31:0]       cpu_wd,
    output logic [31:0]       cpu_rd,
    output logic              nn_run_inference,
    input  logic              nn_ready,
    input  logic [RAM_AW-1:0] nn_address,
    input  logic [7:0]        nn_wd,
    input  logic              nn_we,
    output logic [7:0]        nn_rd,
    output logic [RAM_AW-1:0] ram_address,
    output logic [7:0]        ram_wd,
    output logic              ram_we,
    input  logic [7:0]        ram_rd,
    output logic              irq
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_RUN   = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    localparam logic [11:0] c_ADDR_CTRL   = 12'h400;
    localparam logic [11:0] c_ADDR_STATUS = 12'h404;
    localparam logic [11:0] c_ADDR_RESULT = 12'h408;
    localparam logic [11:0] c_ADDR_CYCLES = 12'h40C;

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic             r_irq_en;
    logic             r_err;
    logic [7:0]       r_result;
    logic [CNT_W-1:0] r_cycles;
    logic [31:0]      r_cpu_rd;

    logic             w_owner;
    logic             w_busy;
    logic             w_done;
    logic             w_pulse;
    logic             w_ram_hit;
    logic             w_ctrl_wr;
    logic             w_start_req;
    logic             w_clear_req;
    logic             w_err_set;
    logic [31:0]      w_cycles_rd;
    logic [31:0]      w_rd_data;
    logic             w_unused;

    assign w_ram_hit   = (cpu_addr[11:10] == 2'b00);
    assign w_ctrl_wr   = cpu_we && (cpu_addr == c_ADDR_CTRL);
    assign w_start_req = w_ctrl_wr & cpu_wd[0];
    assign w_clear_req = w_ctrl_wr & cpu_wd[1];
    assign w_err_set   = (w_start_req & w_busy) | (w_owner & w_ram_hit & (cpu_we | cpu_re));
    assign w_unused    = &{1'b0, cpu_wd[31:8]};

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; in DONE a start request wins over clear_done
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (w_start_req) w_next_state = c_START;
            c_START: w_next_state = c_RUN;
            c_RUN:   if (nn_ready) w_next_state = c_DONE;
            c_DONE: begin
                if (w_start_req) begin
                    w_next_state = c_START;
                end else if (w_clear_req) begin
                    w_next_state = c_IDLE;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    // State-decoded outputs; ownership follows the state register so reset
    // hands the RAM back to the CPU without waiting for a clock edge
    always_comb begin
        w_owner = 1'b0;
        w_busy  = 1'b0;
        w_done  = 1'b0;
        w_pulse = 1'b0;
        case (r_state)
            c_START: begin
                w_owner = 1'b1;
                w_busy  = 1'b1;
                w_pulse = 1'b1;
            end
            c_RUN: begin
                w_owner = 1'b1;
                w_busy  = 1'b1;
            end
            c_DONE:  w_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_irq_en <= 1'b0;
            r_err    <= 1'b0;
            r_result <= 8'h00;
            r_cycles <= '0;
            r_cpu_rd <= 32'h0;
        end else begin
            if (w_ctrl_wr) begin
                r_irq_en <= cpu_wd[2];
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (w_clear_req) begin
                r_err <= 1'b0;
            end
            if (nn_we && w_owner) begin
                r_result <= nn_wd;
            end
            if (r_state == c_START) begin
                r_cycles <= '0;
            end else if ((r_state == c_RUN) && (r_cycles != {CNT_W{1'b1}})) begin
                r_cycles <= r_cycles + c_CNT_ONE;
            end
            if (cpu_re) begin
                r_cpu_rd <= w_rd_data;
            end
        end
    end

    generate
        if (CNT_W >= 32) begin : g_cyc_trunc
            assign w_cycles_rd = r_cycles[31:0];
        end else begin : g_cyc_ext
            assign w_cycles_rd = {{(32-CNT_W){1'b0}}, r_cycles};
        end
    endgenerate

    // Read data reflects pre-write register values on a combined read/write
    always_comb begin
        w_rd_data = 32'h0;
        if (w_ram_hit) begin
            w_rd_data = w_owner ? 32'h0 : {24'h0, ram_rd};
        end else begin
            case (cpu_addr)
                c_ADDR_CTRL:   w_rd_data = {29'h0, r_irq_en, 2'b00};
                c_ADDR_STATUS: w_rd_data = {28'h0, r_err, w_done, w_busy, w_owner};
                c_ADDR_RESULT: w_rd_data = {24'h0, r_result};
                c_ADDR_CYCLES: w_rd_data = w_cycles_rd;
                default:       w_rd_data = 32'h0;
            endcase
        end
    end

    assign ram_address      = w_owner ? nn_address : cpu_addr[RAM_AW-1:0];
    assign ram_wd           = w_owner ? nn_wd : cpu_wd[7:0];
    assign ram_we           = w_owner ? nn_we : (cpu_we & w_ram_hit);
    assign nn_rd            = w_owner ? ram_rd : 8'h00;
    assign nn_run_inference = w_pulse;
    assign irq              = w_done & r_irq_en;
    assign cpu_rd           = r_cpu_rd;

endmodule
`default_nettype wire

// File: doc/nn_host_bridge.md
NN_HOST_BRIDGE -- requirements
Module: nn_host_bridge

Interface
REQ-001 SHALL have parameter RAM_AW, default 10, giving the shared RAM address width.
REQ-002 SHALL have parameter CNT_W, default 32, giving the run-cycle counter width.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low; reset=0 forces the reset state immediately.
REQ-005 CPU-side ports: cpu_re in 1, cpu_we in 1, cpu_addr in 12, cpu_wd in 32, cpu_rd out 32 (word-addressed CPU bus slave).
REQ-006 Neural-side ports: nn_run_inference out 1, nn_ready in 1, nn_address in RAM_AW, nn_wd in 8, nn_we in 1, nn_rd out 8.
REQ-007 RAM-side ports: ram_address out RAM_AW, ram_wd out 8, ram_we out 1, ram_rd in 8 (combinational-read RAM).
REQ-008 irq, out, 1: level interrupt, high while the done flag is set and irq_en=1.

Function
REQ-009 Address map: 0x000-0x3FF RAM window (byte in cpu_wd[7:0]); 0x400 CTRL; 0x404 STATUS; 0x408 RESULT; 0x40C CYCLES; other addresses read 0, writes ignored.
REQ-010 CTRL write: bit0=start, bit1=clear_done, bit2=irq_en (stored); CTRL read returns {29'b0, irq_en, 2'b0}.
REQ-011 STATUS read: {28'b0, err, done, busy, owner}; owner=1 when the neural side owns the RAM.
REQ-012 FSM states: IDLE, START, RUN, DONE.
REQ-013 IDLE->START on a CTRL write with start=1; no transition otherwise.
REQ-014 START: nn_run_inference=1 for exactly one cycle; owner=1; cycle counter cleared to 0; always advances to RUN.
REQ-015 RUN: owner=1; stays in RUN until nn_ready=1 is sampled, then goes to DONE; nn_ready is ignored in START.
REQ-016 DONE: owner=0, done=1; goes to IDLE on clear_done=1; goes directly to START on start=1 (start wins when both bits are set).
REQ-017 busy=1 in START and RUN, 0 otherwise; a start written while busy is ignored and sets err.
REQ-018 Owner=1: ram_address/ram_wd/ram_we = nn_address/nn_wd/nn_we, and nn_rd=ram_rd.
REQ-019 Owner=0: ram_address=cpu_addr[RAM_AW-1:0], ram_wd=cpu_wd[7:0], ram_we=cpu_we & RAM window hit, and nn_rd=0.
REQ-020 CPU RAM-window write while owner=1: dropped (ram_we stays under neural control) and sets err.
REQ-021 CPU RAM-window read while owner=1: returns 0 and sets err.
REQ-022 cpu_rd is registered: data is valid the cycle after cpu_re=1 and holds until the next cpu_re.
REQ-023 RAM reads return {24'b0, ram_rd} sampled in the same cycle as cpu_re.
REQ-024 RESULT captures nn_wd on every cycle with nn_we=1 and owner=1; RESULT reads as {24'b0, result}.
REQ-025 CYCLES increments by 1 each cycle in RUN and saturates at all-ones; it holds its value in DONE and IDLE.
REQ-026 err is sticky; it is cleared only by a CTRL write with clear_done=1.
REQ-027 CPU simultaneous cpu_re and cpu_we: the write takes effect, and the read returns the pre-write value.

Reset
REQ-028 reset=0 SHALL force: FSM=IDLE, owner=0, nn_run_inference=0, busy=done=err=irq_en=0, result=0, cycles=0, cpu_rd=0, irq=0.
REQ-029 Reset during RUN SHALL abort immediately; RAM ownership returns to the CPU with no ram_we glitch from the neural side after reset asserts.
REQ-030 After reset deasserts, the FSM SHALL stay in IDLE until a new start write.

Verification
REQ-031 CPU writes 0x5A at 0x010, reads 0x010 -> cpu_rd=0x0000005A one cycle after cpu_re.
REQ-032 Write CTRL=0x5, model asserts nn_ready 40 cycles after the pulse -> one-cycle nn_run_inference; STATUS=0x3 during the run; then STATUS=0x4, CYCLES=40, irq=1.
REQ-033 During RUN the model writes 0x07 to RAM 0x3F0 -> RAM holds 0x07, RESULT=0x07, and a concurrent CPU write to 0x3F0 is dropped with err=1.
REQ-034 In DONE, write CTRL=0x3 -> re-enters START the next cycle (start wins) and done clears.
REQ-035 Assert reset mid-RUN -> all outputs at reset values asynchronously; a subsequent CPU RAM write/read at 0x000 succeeds.
REQ-036 Start written while busy -> ignored, no second pulse, err=1; CTRL=0x2 then clears err and done.
